// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types for the serial magnitude comparator
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        CMP_LT = 2'b00,
        CMP_EQ = 2'b01,
        CMP_GT = 2'b10
    } cmp_res_e;

    function automatic cmp_res_e digit_result(input logic gt, input logic eq);
        if (eq) begin
            return CMP_EQ;
        end
        return gt ? CMP_GT : CMP_LT;
    endfunction

endpackage

// File: rtl/digit_cmp.sv
// rtl/digit_cmp.sv - combinational D-bit unsigned greater-than / equal compare
module digit_cmp #(
    parameter int D = 2
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    output logic         gt,
    output logic         eq
);

    assign gt = (x > y);
    assign eq = (x == y);

endmodule

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - MSB-first multi-cycle magnitude comparator, D bits per clock
module serial_mag_cmp
    import serial_cmp_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    localparam int N  = W / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    localparam logic [W-1:0]  MSB_MASK = {1'b1, {(W-1){1'b0}}};

    if (W < 2 || D < 1 || D > W || (W % D) != 0) begin : g_param_check
        $error("serial_mag_cmp: need W >= 2, 1 <= D <= W and W %% D == 0");
    end

    state_e         state_q, state_d;
    logic [W-1:0]   sa_q, sa_d;
    logic [W-1:0]   sb_q, sb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;
    logic           gt_q, gt_d;
    logic           eq_q, eq_d;
    logic           lt_q, lt_d;

    logic           dig_gt;
    logic           dig_eq;
    cmp_res_e       dig_res;

    digit_cmp #(.D(D)) u_digit_cmp (
        .x  (sa_q[W-1 -: D]),
        .y  (sb_q[W-1 -: D]),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        dig_res = digit_result(dig_gt, dig_eq);

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto offset binary,
                    // so the digit datapath only ever does unsigned compares.
                    sa_d    = a ^ (signed_mode ? MSB_MASK : '0);
                    sb_d    = b ^ (signed_mode ? MSB_MASK : '0);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dig_res != CMP_EQ) begin
                    gt_d    = (dig_res == CMP_GT);
                    lt_d    = (dig_res == CMP_LT);
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    sa_d  = sa_q << D;
                    sb_d  = sb_q << D;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign gt    = gt_q;
    assign eq    = eq_q;
    assign lt    = lt_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb/tb_serial_mag_cmp.sv - directed bench for serial_mag_cmp plus W=16 digit-width sweep
module tb_serial_mag_cmp;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready, done, gt, eq, lt;

    logic        s_start;
    logic        s_sm;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic [2:0]  rdy, dn, g, e, l;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_mag_cmp #(.W(8), .D(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(sm),
        .a(a), .b(b), .ready(ready), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    serial_mag_cmp #(.W(16), .D(1)) dut_d1 (
        .clk(clk), .reset_n(reset_n), .start(s_start), .signed_mode(s_sm),
        .a(s_a), .b(s_b), .ready(rdy[0]), .done(dn[0]), .gt(g[0]), .eq(e[0]), .lt(l[0])
    );

    serial_mag_cmp #(.W(16), .D(4)) dut_d4 (
        .clk(clk), .reset_n(reset_n), .start(s_start), .signed_mode(s_sm),
        .a(s_a), .b(s_b), .ready(rdy[1]), .done(dn[1]), .gt(g[1]), .eq(e[1]), .lt(l[1])
    );

    serial_mag_cmp #(.W(16), .D(16)) dut_d16 (
        .clk(clk), .reset_n(reset_n), .start(s_start), .signed_mode(s_sm),
        .a(s_a), .b(s_b), .ready(rdy[2]), .done(dn[2]), .gt(g[2]), .eq(e[2]), .lt(l[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Counts edges after the accepting edge until done is seen; cyc starts at already-elapsed edges.
    task automatic wait_done(input int first, output int cyc, output logic [2:0] res,
                             output logic rdy_at_done);
        cyc         = first;
        res         = 3'b000;
        rdy_at_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                res         = {gt, eq, lt};
                rdy_at_done = ready;
                break;
            end
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !ready; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run8(input logic smode, input logic [7:0] av, input logic [7:0] bv,
                        output int cyc, output logic [2:0] res, output logic rdy_at_done);
        wait_ready();
        start = 1'b1; sm = smode; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, cyc, res, rdy_at_done);
    endtask

    function automatic logic [2:0] ref_result(input logic smode, input logic [15:0] x,
                                              input logic [15:0] y);
        if (smode) begin
            if ($signed(x) > $signed(y)) return 3'b100;
            if ($signed(x) < $signed(y)) return 3'b001;
            return 3'b010;
        end
        if (x > y) return 3'b100;
        if (x < y) return 3'b001;
        return 3'b010;
    endfunction

    function automatic int ref_digits(input logic [15:0] x, input logic [15:0] y, input int d);
        logic [15:0] diff;
        logic [31:0] mask;
        diff = x ^ y;
        mask = (32'd1 << d) - 32'd1;
        for (int i = 0; i < 16 / d; i++) begin
            if (((32'(diff) >> (16 - d * (i + 1))) & mask) != 0) return i + 1;
        end
        return 16 / d;
    endfunction

    task automatic run16(input logic smode, input logic [15:0] av, input logic [15:0] bv);
        int          cyc [3];
        logic [2:0]  res [3];
        int          dw  [3];
        logic [2:0]  exp;
        logic [15:0] fa, fb;
        dw[0] = 1; dw[1] = 4; dw[2] = 16;
        for (int i = 0; i < 50 && (rdy != 3'b111); i++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 99;
            res[k] = 3'b000;
        end
        s_start = 1'b1; s_sm = smode; s_a = av; s_b = bv;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (dn[k] && cyc[k] == 99) begin
                    cyc[k] = i;
                    res[k] = {g[k], e[k], l[k]};
                end
            end
            if (cyc[0] != 99 && cyc[1] != 99 && cyc[2] != 99) break;
        end
        exp = ref_result(smode, av, bv);
        fa  = smode ? (av ^ 16'h8000) : av;
        fb  = smode ? (bv ^ 16'h8000) : bv;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sweep_D%0d_res_%h_%h_s%0d", dw[k], av, bv, smode), 32'(res[k]), 32'(exp));
            check($sformatf("sweep_D%0d_lat_%h_%h_s%0d", dw[k], av, bv, smode), cyc[k] + 1,
                  ref_digits(fa, fb, dw[k]) + 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        logic [2:0] res;
        logic       rad;
        logic       bad;
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vs [6];

        reset_n = 1'b0; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        s_start = 1'b0; s_sm = 1'b0; s_a = '0; s_b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_results", {gt, eq, lt}, 3'b000);

        run8(1'b0, 8'hC3, 8'h41, cyc, res, rad);
        check("c3_41_lat", cyc, 1);
        check("c3_41_res", res, 3'b100);
        check("c3_41_ready_at_done", rad, 0);
        @(posedge clk); #1;
        check("c3_41_ready_after", ready, 1);
        check("c3_41_done_pulse", done, 0);

        run8(1'b0, 8'h5A, 8'h5A, cyc, res, rad);
        check("eq_u_lat", cyc, 4);
        check("eq_u_res", res, 3'b010);
        run8(1'b1, 8'h5A, 8'h5A, cyc, res, rad);
        check("eq_s_lat", cyc, 4);
        check("eq_s_res", res, 3'b010);

        run8(1'b0, 8'hFF, 8'h01, cyc, res, rad);
        check("ff_01_u_res", res, 3'b100);
        check("ff_01_u_lat", cyc, 1);
        run8(1'b1, 8'hFF, 8'h01, cyc, res, rad);
        check("ff_01_s_res", res, 3'b001);
        run8(1'b1, 8'h80, 8'h7F, cyc, res, rad);
        check("80_7f_s_res", res, 3'b001);

        run8(1'b0, 8'h80, 8'h81, cyc, res, rad);
        check("80_81_lat", cyc, 4);
        check("80_81_res", res, 3'b001);
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if ({gt, eq, lt} !== 3'b001 || done !== 1'b0) bad = 1'b1;
        end
        check("hold_10_idle", bad, 0);

        // A start pulse with different operands in the middle of RUN must be ignored.
        wait_ready();
        start = 1'b1; sm = 1'b0; a = 8'h80; b = 8'h81;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; sm = 1'b1; a = 8'hFF; b = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, cyc, res, rad);
        check("ignore_start_lat", cyc, 4);
        check("ignore_start_res", res, 3'b001);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ignore_start_no_queue", {ready, done}, 2'b10);

        // Start held high across done: second op taken from the following IDLE cycle.
        wait_ready();
        start = 1'b1; sm = 1'b0; a = 8'h10; b = 8'h20;
        @(posedge clk); #1;
        wait_done(0, cyc, res, rad);
        check("held_first_lat", cyc, 2);
        check("held_first_res", res, 3'b001);
        a = 8'h20; b = 8'h10;
        @(posedge clk); #1;
        check("held_idle_ready", {ready, done}, 2'b10);
        @(posedge clk); #1;
        check("held_accepted", ready, 0);
        start = 1'b0;
        wait_done(0, cyc, res, rad);
        check("held_second_lat", cyc, 2);
        check("held_second_res", res, 3'b100);

        wait_ready();
        start = 1'b1; sm = 1'b0; a = 8'h5A; b = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_results", {gt, eq, lt}, 3'b000);
        check("abort_done", done, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || ready !== 1'b1) bad = 1'b1;
        end
        check("abort_no_done", bad, 0);

        va[0] = 16'h0000; vb[0] = 16'h0000; vs[0] = 1'b0;
        va[1] = 16'h1234; vb[1] = 16'h1235; vs[1] = 1'b0;
        va[2] = 16'h8000; vb[2] = 16'h7FFF; vs[2] = 1'b1;
        va[3] = 16'hFFFF; vb[3] = 16'h0001; vs[3] = 1'b1;
        va[4] = 16'hFFFF; vb[4] = 16'h0001; vs[4] = 1'b0;
        va[5] = 16'hA5F0; vb[5] = 16'hA5F0; vs[5] = 1'b1;
        for (int i = 0; i < 6; i++) run16(vs[i], va[i], vb[i]);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = (i % 2 == 0) ? (ra ^ (16'd1 << $urandom_range(0, 15))) : 16'($urandom);
            run16(1'($urandom_range(0, 1)), ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
